// File: rtl/mem_arb_pkg.sv
// Shared definitions for the memory request round-robin arbiter.
package mem_arb_pkg;

  // Default number of granted-but-unanswered requests tracked by the ID FIFO.
  localparam int unsigned DEFAULT_MAX_OUTSTANDING = 32'd4;

  // Width of an index into n items; a single item still needs one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    if (n > 32'd1) begin
      return $clog2(n);
    end else begin
      return 32'd1;
    end
  endfunction

endpackage

// File: rtl/fifo_v3.sv
// Small synchronous FIFO with optional fall-through, used to hold port IDs
// of requests that were granted by memory and still await a response.
module fifo_v3
  import mem_arb_pkg::*;
#(
  parameter bit          FALL_THROUGH = 1'b0,
  parameter int unsigned DATA_WIDTH   = 32'd32,
  parameter int unsigned DEPTH        = 32'd8
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  flush_i,
  input  logic                  testmode_i,
  output logic                  full_o,
  output logic                  empty_o,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  push_i,
  output logic [DATA_WIDTH-1:0] data_o,
  input  logic                  pop_i
);

  localparam int unsigned         ADDR_DEPTH = idx_width(DEPTH);
  localparam logic [ADDR_DEPTH-1:0] PTR_LAST = ADDR_DEPTH'(DEPTH - 32'd1);
  localparam logic [ADDR_DEPTH-1:0] PTR_ONE  = ADDR_DEPTH'(1'b1);
  localparam logic [ADDR_DEPTH:0]   CNT_FULL = (ADDR_DEPTH + 1)'(DEPTH);
  localparam logic [ADDR_DEPTH:0]   CNT_ONE  = (ADDR_DEPTH + 1)'(1'b1);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [ADDR_DEPTH-1:0] rptr_q, rptr_d, wptr_q, wptr_d;
  logic [ADDR_DEPTH:0]   cnt_q, cnt_d;
  logic                  wr_en_s;
  logic                  unused_testmode;

  // Test mode has no effect on this storage-only FIFO.
  assign unused_testmode = testmode_i;

  assign full_o  = (cnt_q == CNT_FULL);
  assign empty_o = (cnt_q == {(ADDR_DEPTH + 1){1'b0}});

  // Pointer and occupancy update; a push into an empty fall-through FIFO that
  // is popped in the same cycle bypasses the storage entirely.
  always_comb begin
    rptr_d  = rptr_q;
    wptr_d  = wptr_q;
    cnt_d   = cnt_q;
    wr_en_s = 1'b0;
    data_o  = mem_q[rptr_q];
    if (push_i && !full_o) begin
      wr_en_s = 1'b1;
      wptr_d  = (wptr_q == PTR_LAST) ? {ADDR_DEPTH{1'b0}} : wptr_q + PTR_ONE;
      cnt_d   = cnt_q + CNT_ONE;
    end else begin
      wr_en_s = 1'b0;
    end
    if (pop_i && !empty_o) begin
      rptr_d = (rptr_q == PTR_LAST) ? {ADDR_DEPTH{1'b0}} : rptr_q + PTR_ONE;
      cnt_d  = cnt_d - CNT_ONE;
    end else begin
      rptr_d = rptr_d;
    end
    if (FALL_THROUGH && empty_o && push_i) begin
      data_o = data_i;
      if (pop_i) begin
        wr_en_s = 1'b0;
        wptr_d  = wptr_q;
        cnt_d   = cnt_q;
      end else begin
        wr_en_s = wr_en_s;
      end
    end else begin
      data_o = data_o;
    end
  end

  // Pointer/occupancy registers; flush empties the FIFO synchronously.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rptr_q <= {ADDR_DEPTH{1'b0}};
      wptr_q <= {ADDR_DEPTH{1'b0}};
      cnt_q  <= {(ADDR_DEPTH + 1){1'b0}};
    end else if (flush_i) begin
      rptr_q <= {ADDR_DEPTH{1'b0}};
      wptr_q <= {ADDR_DEPTH{1'b0}};
      cnt_q  <= {(ADDR_DEPTH + 1){1'b0}};
    end else begin
      rptr_q <= rptr_d;
      wptr_q <= wptr_d;
      cnt_q  <= cnt_d;
    end
  end

  // Entry storage; contents are only meaningful between push and pop.
  always_ff @(posedge clk_i) begin
    if (wr_en_s) begin
      mem_q[wptr_q] <= data_i;
    end
  end

endmodule

// File: rtl/mem_req_rr_arbiter.sv
// Round-robin arbiter sharing one in-order SRAM-style memory port among
// NUM_PORTS requesters; an ID FIFO routes each response back to its owner.
module mem_req_rr_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned NUM_PORTS       = 32'd2,
  parameter int unsigned ADDR_WIDTH      = 32'd32,
  parameter int unsigned DATA_WIDTH      = 32'd32,
  parameter int unsigned MAX_OUTSTANDING = DEFAULT_MAX_OUTSTANDING
) (
  input  logic                                clk_i,
  input  logic                                rst_i,
  input  logic [NUM_PORTS-1:0]                req_valid_i,
  output logic [NUM_PORTS-1:0]                req_ready_o,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0]     req_addr_i,
  input  logic [NUM_PORTS-1:0]                req_we_i,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0]     req_wdata_i,
  input  logic [NUM_PORTS*DATA_WIDTH/8-1:0]   req_strb_i,
  output logic [NUM_PORTS-1:0]                rsp_valid_o,
  output logic [DATA_WIDTH-1:0]               rsp_rdata_o,
  output logic                                mem_req_o,
  input  logic                                mem_gnt_i,
  output logic [ADDR_WIDTH-1:0]               mem_addr_o,
  output logic                                mem_we_o,
  output logic [DATA_WIDTH-1:0]               mem_wdata_o,
  output logic [DATA_WIDTH/8-1:0]             mem_strb_o,
  input  logic                                mem_rvalid_i,
  input  logic [DATA_WIDTH-1:0]               mem_rdata_i,
  output logic                                idle_o,
  output logic                                err_o
);

  localparam int unsigned          IDX_W     = idx_width(NUM_PORTS);
  localparam int unsigned          STRB_W    = DATA_WIDTH / 32'd8;
  localparam logic [IDX_W-1:0]     LAST_PORT = IDX_W'(NUM_PORTS - 32'd1);
  localparam logic [IDX_W-1:0]     IDX_ONE   = IDX_W'(1'b1);
  localparam logic [NUM_PORTS-1:0] PORT_ONE  = NUM_PORTS'(1'b1);

  logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0] sel_q, sel_d;
  logic             lock_q, lock_d;
  logic             err_q, err_d;
  logic [IDX_W-1:0] search_s, cand_s, sel_s, head_s;
  logic             found_s, mem_req_s, hs_s, pop_s, fifo_full_s, fifo_empty_s;

  // Round-robin search: first valid port at or above rr_ptr, wrapping around.
  always_comb begin
    found_s  = 1'b0;
    search_s = {IDX_W{1'b0}};
    cand_s   = {IDX_W{1'b0}};
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      cand_s = IDX_W'((32'(rr_ptr_q) + i) % NUM_PORTS);
      if (!found_s && req_valid_i[cand_s]) begin
        found_s  = 1'b1;
        search_s = cand_s;
      end else begin
        found_s  = found_s;
      end
    end
  end

  // A request left waiting for grant keeps its port so mem_* stays stable.
  assign sel_s     = lock_q ? sel_q : search_s;
  assign mem_req_s = (|req_valid_i) & ~fifo_full_s & ~rst_i;
  assign hs_s      = mem_req_s & mem_gnt_i;
  assign pop_s     = mem_rvalid_i & ~fifo_empty_s & ~rst_i;

  assign mem_req_o   = mem_req_s;
  assign mem_addr_o  = req_addr_i[sel_s*ADDR_WIDTH +: ADDR_WIDTH];
  assign mem_we_o    = req_we_i[sel_s];
  assign mem_wdata_o = req_wdata_i[sel_s*DATA_WIDTH +: DATA_WIDTH];
  assign mem_strb_o  = req_strb_i[sel_s*STRB_W +: STRB_W];
  assign req_ready_o = hs_s ? (PORT_ONE << sel_s) : {NUM_PORTS{1'b0}};
  assign rsp_valid_o = pop_s ? (PORT_ONE << head_s) : {NUM_PORTS{1'b0}};
  assign rsp_rdata_o = mem_rdata_i;
  assign idle_o      = fifo_empty_s & ~(|req_valid_i);
  assign err_o       = err_q;

  // Next-state for pointer, lock, held selection and sticky error.
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    sel_d    = sel_q;
    lock_d   = lock_q;
    err_d    = err_q;
    if (hs_s) begin
      rr_ptr_d = (sel_s == LAST_PORT) ? {IDX_W{1'b0}} : sel_s + IDX_ONE;
      lock_d   = 1'b0;
    end else if (mem_req_s) begin
      lock_d   = 1'b1;
      sel_d    = sel_s;
    end else begin
      lock_d   = lock_q;
    end
    if (mem_rvalid_i && fifo_empty_s) begin
      err_d = 1'b1;
    end else begin
      err_d = err_q;
    end
  end

  // Arbitration state registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rr_ptr_q <= {IDX_W{1'b0}};
      sel_q    <= {IDX_W{1'b0}};
      lock_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      sel_q    <= sel_d;
      lock_q   <= lock_d;
      err_q    <= err_d;
    end
  end

  fifo_v3 #(
    .FALL_THROUGH (1'b0),
    .DATA_WIDTH   (IDX_W),
    .DEPTH        (MAX_OUTSTANDING)
  ) i_id_fifo (
    .clk_i      (clk_i),
    .rst_ni     (1'b1),
    .flush_i    (rst_i),
    .testmode_i (1'b0),
    .full_o     (fifo_full_s),
    .empty_o    (fifo_empty_s),
    .data_i     (sel_s),
    .push_i     (hs_s),
    .data_o     (head_s),
    .pop_i      (pop_s)
  );

endmodule

// File: tb/tb_mem_req_rr_arbiter.sv
// Directed bench for mem_req_rr_arbiter with a queue-based reference model.
module tb_mem_req_rr_arbiter;

  localparam int NP = 2;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = DW / 8;
  localparam int MO = 4;

  logic              clk_i = 1'b0;
  logic              rst_i;
  logic [NP-1:0]     req_valid_i, req_ready_o, req_we_i, rsp_valid_o;
  logic [NP*AW-1:0]  req_addr_i;
  logic [NP*DW-1:0]  req_wdata_i;
  logic [NP*SW-1:0]  req_strb_i;
  logic [DW-1:0]     rsp_rdata_o, mem_wdata_o, mem_rdata_i;
  logic              mem_req_o, mem_gnt_i, mem_we_o, mem_rvalid_i, idle_o, err_o;
  logic [AW-1:0]     mem_addr_o;
  logic [SW-1:0]     mem_strb_o;

  mem_req_rr_arbiter #(.NUM_PORTS(NP), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_OUTSTANDING(MO)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_addr_i(req_addr_i), .req_we_i(req_we_i), .req_wdata_i(req_wdata_i), .req_strb_i(req_strb_i),
    .rsp_valid_o(rsp_valid_o), .rsp_rdata_o(rsp_rdata_o), .mem_req_o(mem_req_o), .mem_gnt_i(mem_gnt_i),
    .mem_addr_o(mem_addr_o), .mem_we_o(mem_we_o), .mem_wdata_o(mem_wdata_o), .mem_strb_o(mem_strb_o),
    .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i), .idle_o(idle_o), .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

  int n_vec = 0;
  int n_err = 0;

  // Reference model state: ports of outstanding requests in grant order.
  int q_out[$];
  int rr_m = 0;
  bit lock_m = 1'b0;
  int lsel_m = 0;
  bit err_m = 1'b0;
  int grant_log[$];
  int rsp_log[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic bit valid_of(input logic [NP-1:0] v, input int p);
    logic [NP-1:0] t;
    t = v >> p;
    return t[0];
  endfunction

  function automatic int pick_port();
    for (int i = 0; i < NP; i++) begin
      if (valid_of(req_valid_i, (rr_m + i) % NP)) return (rr_m + i) % NP;
    end
    return 0;
  endfunction

  function automatic int onehot_idx(input logic [NP-1:0] v);
    for (int i = 0; i < NP; i++) begin
      if (valid_of(v, i)) return i;
    end
    return -1;
  endfunction

  // Compare process: checks every output against the model each cycle.
  int s_m;
  bit ereq_m, hs_m;
  logic [NP-1:0]    erdy_m, ersp_m;
  logic [NP*AW-1:0] ta;
  logic [NP*DW-1:0] td;
  logic [NP*SW-1:0] ts;
  always @(negedge clk_i) begin
    if (rst_i) begin
      chk("rst_mem_req", 64'(mem_req_o), 64'd0);
      chk("rst_ready", 64'(req_ready_o), 64'd0);
      chk("rst_rsp", 64'(rsp_valid_o), 64'd0);
      q_out.delete();
      rr_m = 0; lock_m = 1'b0; err_m = 1'b0;
    end else begin
      s_m    = lock_m ? lsel_m : pick_port();
      ereq_m = (req_valid_i != '0) && (q_out.size() < MO);
      hs_m   = ereq_m && mem_gnt_i;
      erdy_m = hs_m ? NP'(1 << s_m) : '0;
      ersp_m = (mem_rvalid_i && q_out.size() > 0) ? NP'(1 << q_out[0]) : '0;
      chk("mem_req", 64'(mem_req_o), 64'(ereq_m));
      chk("req_ready", 64'(req_ready_o), 64'(erdy_m));
      chk("rsp_valid", 64'(rsp_valid_o), 64'(ersp_m));
      chk("err", 64'(err_o), 64'(err_m));
      chk("idle", 64'(idle_o), 64'((q_out.size() == 0) && (req_valid_i == '0)));
      if (ereq_m) begin
        ta = req_addr_i >> (s_m * AW);
        td = req_wdata_i >> (s_m * DW);
        ts = req_strb_i >> (s_m * SW);
        chk("mem_addr", 64'(mem_addr_o), 64'(AW'(ta)));
        chk("mem_we", 64'(mem_we_o), 64'(valid_of(req_we_i, s_m)));
        chk("mem_wdata", 64'(mem_wdata_o), 64'(DW'(td)));
        chk("mem_strb", 64'(mem_strb_o), 64'(SW'(ts)));
      end
      if (ersp_m != '0) chk("rsp_rdata", 64'(rsp_rdata_o), 64'(mem_rdata_i));
      if (req_ready_o != '0) grant_log.push_back(onehot_idx(req_ready_o));
      if (rsp_valid_o != '0) rsp_log.push_back(onehot_idx(rsp_valid_o));
      // Advance the model to the state after the coming rising edge.
      if (mem_rvalid_i) begin
        if (q_out.size() > 0) void'(q_out.pop_front());
        else err_m = 1'b1;
      end
      if (hs_m) begin
        q_out.push_back(s_m);
        rr_m = (s_m + 1) % NP;
        lock_m = 1'b0;
      end else if (ereq_m) begin
        lock_m = 1'b1;
        lsel_m = s_m;
      end
    end
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic mid();
    #5;
  endtask

  task automatic set_ports(input logic [31:0] a0, input logic [31:0] a1);
    req_addr_i  = {a1, a0};
    req_wdata_i = {a1 ^ 32'hA5A5_0000, a0 ^ 32'h0000_5A5A};
    req_strb_i  = {4'b1100, 4'b0011};
    req_we_i    = 2'b10;
  endtask

  initial begin
    rst_i = 1'b1; req_valid_i = 2'b00; mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0;
    mem_rdata_i = 32'h0; set_ports(32'h100, 32'h200);
    repeat (3) tick();
    rst_i = 1'b0;
    // Reset release, no traffic.
    mid();
    chk("lit_idle_after_rst", 64'(idle_o), 64'd1);
    chk("lit_req_after_rst", 64'(mem_req_o), 64'd0);
    chk("lit_err_after_rst", 64'(err_o), 64'd0);
    tick();

    // Both ports valid, immediate grant, response one cycle later.
    grant_log.delete(); rsp_log.delete();
    req_valid_i = 2'b11; mem_gnt_i = 1'b1;
    mid();
    chk("lit_first_addr", 64'(mem_addr_o), 64'h100);
    tick();
    for (int c = 0; c < 3; c++) begin
      mem_rvalid_i = 1'b1; mem_rdata_i = 32'hD000_0000 + 32'(c);
      tick();
    end
    req_valid_i = 2'b00; mem_rdata_i = 32'hD000_00FF;
    tick();
    mem_rvalid_i = 1'b0;
    tick();
    chk("lit_alt_ngrant", 64'(grant_log.size()), 64'd4);
    chk("lit_alt_nrsp", 64'(rsp_log.size()), 64'd4);
    for (int i = 0; i < 4; i++) begin
      if (i < grant_log.size()) chk("lit_alt_grant", 64'(grant_log[i]), 64'(i % 2));
      if (i < rsp_log.size())   chk("lit_alt_rsp", 64'(rsp_log[i]), 64'(i % 2));
    end

    // Port 1 waits three cycles for grant while port 0 joins; selection holds.
    grant_log.delete();
    set_ports(32'h80, 32'h40);
    req_valid_i = 2'b10; mem_gnt_i = 1'b0;
    tick();
    req_valid_i = 2'b11;
    mid();
    chk("lit_lock_addr_c2", 64'(mem_addr_o), 64'h40);
    tick();
    tick();
    mem_gnt_i = 1'b1;
    mid();
    chk("lit_lock_addr_gnt", 64'(mem_addr_o), 64'h40);
    chk("lit_lock_ready", 64'(req_ready_o), 64'h2);
    tick();
    req_valid_i = 2'b01;
    tick();
    req_valid_i = 2'b00; mem_rvalid_i = 1'b1;
    repeat (2) tick();
    mem_rvalid_i = 1'b0;
    tick();
    chk("lit_lock_ngrant", 64'(grant_log.size()), 64'd2);
    if (grant_log.size() == 2) begin
      chk("lit_lock_g0", 64'(grant_log[0]), 64'd1);
      chk("lit_lock_g1", 64'(grant_log[1]), 64'd0);
    end

    // Fill all four outstanding slots, then observe the full stall.
    set_ports(32'h300, 32'h400);
    req_valid_i = 2'b11; mem_gnt_i = 1'b1;
    repeat (4) tick();
    mid();
    chk("lit_full_req", 64'(mem_req_o), 64'd0);
    chk("lit_full_ready", 64'(req_ready_o), 64'd0);
    tick();
    mem_rvalid_i = 1'b1; mem_rdata_i = 32'hBEEF_0001;
    mid();
    chk("lit_full_pop_req", 64'(mem_req_o), 64'd0);
    chk("lit_full_pop_rsp", 64'(rsp_valid_o), 64'h2);
    tick();
    mem_rvalid_i = 1'b0;
    mid();
    chk("lit_after_full_ready", 64'(req_ready_o), 64'h2);
    tick();
    req_valid_i = 2'b00; mem_rvalid_i = 1'b1;
    repeat (4) tick();
    mem_rvalid_i = 1'b0;
    tick();

    // Response with nothing outstanding raises the sticky error.
    mem_rvalid_i = 1'b1;
    mid();
    chk("lit_orphan_rsp", 64'(rsp_valid_o), 64'd0);
    tick();
    mem_rvalid_i = 1'b0;
    mid();
    chk("lit_err_set", 64'(err_o), 64'd1);
    repeat (3) tick();
    chk("lit_err_sticky", 64'(err_o), 64'd1);
    tick();

    // Reset with two outstanding requests.
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    mid();
    chk("lit_err_cleared", 64'(err_o), 64'd0);
    tick();
    req_valid_i = 2'b10;
    tick();
    req_valid_i = 2'b01;
    tick();
    req_valid_i = 2'b00;
    tick();
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    mid();
    chk("lit_idle_post_rst", 64'(idle_o), 64'd1);
    tick();
    req_valid_i = 2'b11;
    mid();
    chk("lit_first_grant_post_rst", 64'(req_ready_o), 64'h1);
    tick();
    req_valid_i = 2'b00; mem_rvalid_i = 1'b1;
    tick();
    mid();
    chk("lit_stale_rsp", 64'(rsp_valid_o), 64'd0);
    tick();
    mem_rvalid_i = 1'b0;
    mid();
    chk("lit_stale_err", 64'(err_o), 64'd1);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
